// File: rtl/store_pkg.sv
// Shared definitions for the store-path data organizer: funct3 size codes,
// FSM state encoding and lane count.
package store_pkg;

    localparam int LANES = 4;

    localparam logic [1:0] ST_B = 2'b00;
    localparam logic [1:0] ST_H = 2'b01;
    localparam logic [1:0] ST_W = 2'b10;

    typedef enum logic [1:0] {
        st_idle,
        st_beat0,
        st_beat1
    } state_t;

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane generator: turns a byte offset, funct3 and register data
// into a two-word strobe map and lane-positioned data.
module store_lane_gen
    import store_pkg::*;
#(
    parameter int size = 32
) (
    input  logic [1:0]           addr,
    input  logic [2:0]           Type_sel,
    input  logic [size-1:0]      data,
    output logic [2*LANES-1:0]   lanes,
    output logic [2*size-1:0]    shdata,
    output logic                 illegal
);

    logic [LANES-1:0] byte_en;
    logic [size-1:0]  masked;

    assign illegal = Type_sel[2] | (Type_sel[1:0] == 2'b11);

    // Low-n-byte enable: lane 0 for any legal size, lane 1 for half/word, upper lanes for word only.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            if (gi == 0) begin : g_b
                assign byte_en[gi] = !illegal;
            end else if (gi == 1) begin : g_h
                assign byte_en[gi] = !illegal && ((Type_sel[1:0] == ST_H) || (Type_sel[1:0] == ST_W));
            end else begin : g_w
                assign byte_en[gi] = !illegal && (Type_sel[1:0] == ST_W);
            end
            assign masked[8*gi +: 8] = byte_en[gi] ? data[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign lanes  = {{LANES{1'b0}}, byte_en} << addr;
    assign shdata = {{size{1'b0}}, masked} << {addr, 3'b000};

endmodule

// File: rtl/store_data_organizer.sv
// Store-path data organizer: accepts one store per handshake and emits one or
// two word-aligned write beats with byte strobes.
module store_data_organizer
    import store_pkg::*;
#(
    parameter int size   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [size-1:0]   req_data,
    input  logic [2:0]        Type_sel,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [size-1:0]   mem_wdata,
    output logic [LANES-1:0]  mem_wstrb,
    output logic              req_err,
    output logic              busy
);

    state_t state_reg, state_next;

    logic [ADDR_W-1:0]  mem_addr_reg, hi_addr_reg;
    logic [size-1:0]    mem_wdata_reg, hi_wdata_reg;
    logic [LANES-1:0]   mem_wstrb_reg, hi_wstrb_reg;
    logic               req_err_reg;

    logic [2*LANES-1:0] lanes;
    logic [2*size-1:0]  shdata;
    logic               illegal;
    logic [ADDR_W-1:0]  base;
    logic               accept, final_beat;
    logic               load_req, load_hi, clear_out;

    store_lane_gen #(.size(size)) u_lane_gen (
        .addr     (req_addr[1:0]),
        .Type_sel (Type_sel),
        .data     (req_data),
        .lanes    (lanes),
        .shdata   (shdata),
        .illegal  (illegal)
    );

    assign base       = {req_addr[ADDR_W-1:2], 2'b00};
    assign final_beat = ((state_reg == st_beat0) && (hi_wstrb_reg == '0)) || (state_reg == st_beat1);
    assign req_ready  = (state_reg == st_idle) || (final_beat && mem_ready);
    assign accept     = req_valid && req_ready;

    assign mem_valid = (state_reg != st_idle);
    assign busy      = (state_reg != st_idle);
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;
    assign req_err   = req_err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= st_idle;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load_req   = 1'b0;
        load_hi    = 1'b0;
        clear_out  = 1'b0;
        case (state_reg)
            st_idle: begin
                if (accept && !illegal) begin
                    state_next = st_beat0;
                    load_req   = 1'b1;
                end
            end
            st_beat0: begin
                if (mem_ready) begin
                    if (hi_wstrb_reg != '0) begin
                        state_next = st_beat1;
                        load_hi    = 1'b1;
                    end else if (accept && !illegal) begin
                        state_next = st_beat0;
                        load_req   = 1'b1;
                    end else begin
                        state_next = st_idle;
                        clear_out  = 1'b1;
                    end
                end
            end
            st_beat1: begin
                if (mem_ready) begin
                    if (accept && !illegal) begin
                        state_next = st_beat0;
                        load_req   = 1'b1;
                    end else begin
                        state_next = st_idle;
                        clear_out  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = st_idle;
                clear_out  = 1'b1;
            end
        endcase
    end

    // Beat outputs are registered; the high word is parked until BEAT0 retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
            hi_addr_reg   <= '0;
            hi_wdata_reg  <= '0;
            hi_wstrb_reg  <= '0;
            req_err_reg   <= 1'b0;
        end else begin
            req_err_reg <= accept && illegal;
            if (load_req) begin
                mem_addr_reg  <= base;
                mem_wstrb_reg <= lanes[LANES-1:0];
                mem_wdata_reg <= shdata[size-1:0];
                hi_addr_reg   <= base + ADDR_W'(4);
                hi_wstrb_reg  <= lanes[2*LANES-1:LANES];
                hi_wdata_reg  <= shdata[2*size-1:size];
            end else if (load_hi) begin
                mem_addr_reg  <= hi_addr_reg;
                mem_wstrb_reg <= hi_wstrb_reg;
                mem_wdata_reg <= hi_wdata_reg;
                hi_wstrb_reg  <= '0;
            end else if (clear_out) begin
                mem_addr_reg  <= '0;
                mem_wstrb_reg <= '0;
                mem_wdata_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_store_data_organizer.sv
// Scoreboard bench for store_data_organizer: a byte-level reference model
// predicts write beats; a negedge monitor checks them as they are handshaken.
module tb_store_data_organizer;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [2:0]  Type_sel = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        req_err;
    logic        busy;

    beat_t exp_q[$];
    logic  err_exp = 1'b0;
    int    rdy_mode = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    logic        held = 1'b0;
    logic [31:0] held_addr, held_wdata;
    logic [3:0]  held_wstrb;

    store_data_organizer dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .Type_sel  (Type_sel),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .req_err   (req_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Reference: walk the stored bytes one at a time and group them by word address.
    task automatic model_push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] ts);
        int n;
        beat_t b;
        logic [31:0] ba;
        logic [31:0] w;
        bit have;
        if (ts[2] || ts[1:0] == 2'b11) begin
            err_exp = 1'b1;
            return;
        end
        n = (ts[1:0] == 2'b00) ? 1 : (ts[1:0] == 2'b01) ? 2 : 4;
        b = '0;
        have = 1'b0;
        for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            w  = {ba[31:2], 2'b00};
            if (have && w != b.addr) begin
                exp_q.push_back(b);
                b = '0;
            end
            b.addr = w;
            b.wstrb[ba[1:0]] = 1'b1;
            b.wdata[ba[1:0]*8 +: 8] = d[8*i +: 8];
            have = 1'b1;
        end
        exp_q.push_back(b);
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] ts);
        int waits = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        Type_sel  = ts;
        @(negedge clk);
        while (!req_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!req_ready) begin
            n_checks++;
            $display("FAIL req_accept_timeout: req_ready stuck at 0, required 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        if (waits < 200) model_push(a, d, ts);
        $display("req  addr=%h data=%h type=%b waits=%0d", a, d, ts, waits);
        req_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic valid_next(input string name, input logic exp_v);
        @(negedge clk);
        check(name, 64'(mem_valid), 64'(exp_v));
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) mem_ready = 1'b1;
            else if (rdy_mode == 1) mem_ready = (($urandom % 4) != 0);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
        end else begin
            check("req_err", 64'(req_err), 64'(err_exp));
            err_exp = 1'b0;
            if (mem_valid && mem_ready) begin
                $display("beat addr=%h wstrb=%b wdata=%h", mem_addr, mem_wstrb, mem_wdata);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got beat at %h, required no beat", mem_addr);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_addr", 64'(mem_addr), 64'(e.addr));
                    check("beat_wstrb", 64'(mem_wstrb), 64'(e.wstrb));
                    check("beat_wdata", 64'(mem_wdata), 64'(e.wdata));
                end
            end
            if (mem_valid && !mem_ready) begin
                check("ready_under_stall", 64'(req_ready), 64'(0));
                if (held) begin
                    check("stall_addr", 64'(mem_addr), 64'(held_addr));
                    check("stall_wstrb", 64'(mem_wstrb), 64'(held_wstrb));
                    check("stall_wdata", 64'(mem_wdata), 64'(held_wdata));
                end
                held = 1'b1;
                held_addr  = mem_addr;
                held_wstrb = mem_wstrb;
                held_wdata = mem_wdata;
            end else begin
                held = 1'b0;
            end
            if (!mem_valid) check("ready_when_idle", 64'(req_ready), 64'(1));
        end
    end

    initial begin
        logic [31:0] a, d;
        logic [2:0]  ts;
        int r;
        int budget;

        @(negedge clk);
        check("rst_mem_valid", 64'(mem_valid), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_wstrb", 64'(mem_wstrb), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycles(1);

        send(32'h100, 32'hDEADBEEF, 3'b010);
        valid_next("lat_word", 1'b1);
        send(32'h203, 32'h123456AB, 3'b000);
        valid_next("lat_byte3", 1'b1);

        send(32'h307, 32'h0000CAFE, 3'b001);
        @(negedge clk);
        check("split_beat0_valid", 64'(mem_valid), 64'(1));
        check("split_beat0_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1;
        idle_cycles(2);

        // Backpressure on both beats of a split word with a competing request pending.
        rdy_mode  = 2;
        mem_ready = 1'b0;
        send(32'h401, 32'h11223344, 3'b010);
        fork
            begin
                repeat (3) @(posedge clk);
                #1 mem_ready = 1'b1;
                @(posedge clk);
                #1 mem_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 mem_ready = 1'b1;
            end
            send(32'h500, 32'hA5A5A5A5, 3'b010);
        join
        rdy_mode = 0;
        idle_cycles(3);

        send(32'h600, 32'h0, 3'b011);
        valid_next("illegal011_no_beat", 1'b0);
        send(32'h604, 32'h0, 3'b100);
        valid_next("illegal100_no_beat", 1'b0);
        idle_cycles(2);

        // Asynchronous reset during BEAT1 of a split half.
        rdy_mode  = 2;
        mem_ready = 1'b0;
        send(32'h707, 32'h0000BEEF, 3'b001);
        mem_ready = 1'b1;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_mem_valid", 64'(mem_valid), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_wstrb", 64'(mem_wstrb), 64'(0));
        check("arst_addr", 64'(mem_addr), 64'(0));
        check("arst_wdata", 64'(mem_wdata), 64'(0));
        check("arst_req_ready", 64'(req_ready), 64'(1));
        exp_q.delete();
        err_exp = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        check("post_rst_ready", 64'(req_ready), 64'(1));
        check("post_rst_valid", 64'(mem_valid), 64'(0));
        @(posedge clk);
        #1;
        idle_cycles(5);

        rdy_mode = 1;
        for (int k = 0; k < 250; k++) begin
            if ($urandom % 4 == 0) idle_cycles(1);
            r = $urandom % 16;
            if (r == 0) ts = 3'b011;
            else if (r == 1) ts = {1'b1, 2'($urandom % 4)};
            else ts = {1'b0, 2'($urandom % 3)};
            a = $urandom;
            if ($urandom % 16 == 0) a = 32'hFFFFFFFC | 32'($urandom % 4);
            d = $urandom;
            send(a, d, ts);
        end

        rdy_mode = 0;
        budget = 0;
        while ((exp_q.size() != 0 || busy) && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        idle_cycles(2);
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/store_data_organizer.md
# store_data_organizer

Store-path counterpart of the load-side data organizer. It accepts one store request per handshake: byte address, register data and funct3 `Type_sel`. It then produces word-aligned data-memory write beats with per-byte strobes. A store that crosses a 32-bit word boundary is split into two sequential beats. The block sits between the execute/memory pipeline stage and the data-memory write port.

## Interface
- `size`, 32: data width in bits; only 32 is supported, giving 4 byte lanes.
- `ADDR_W`, 32: address width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid` input 1: store request present.
- `req_ready` output 1: the request is accepted when `req_valid && req_ready`.
- `req_addr` input ADDR_W: byte address.
- `req_data` input size: register source data, right-justified.
- `Type_sel` input 3: funct3. `[1:0]` = 00 byte, 01 half, 10 word; 11 is illegal. `Type_sel[2]=1` is illegal for stores.
- `mem_valid` output 1: a write beat is presented.
- `mem_ready` input 1: the memory accepts the beat when `mem_valid && mem_ready`.
- `mem_addr` output ADDR_W: word-aligned beat address; bits `[1:0]` are always 0.
- `mem_wdata` output size: lane-positioned write data.
- `mem_wstrb` output 4: byte-lane strobes.
- `req_err` output 1: one-cycle pulse for an illegal `Type_sel`.
- `busy` output 1: high whenever the FSM is not IDLE.

## Operation
- **States.**
  - IDLE: no beat outstanding.
  - BEAT0: low-word beat presented.
  - BEAT1: high-word beat of a split store presented.
- **`req_ready`** = (state==IDLE) || (state is on its final beat && `mem_ready`). This allows back-to-back stores with no bubble.
- **On acceptance**, the block registers the following values:
  - `off = req_addr[1:0]`
  - `n` = 1, 2 or 4 bytes
  - `lanes[7:0] = ((1<<n)-1) << off`
  - `shdata[63:0] = {32'b0, req_data & low-n-byte mask} << (8*off)`
  - `base = {req_addr[ADDR_W-1:2], 2'b00}`
- **BEAT0 outputs:** `mem_addr=base`, `mem_wstrb=lanes[3:0]`, `mem_wdata=shdata[31:0]`.
- **BEAT0 exit on `mem_ready`:**
  - If `lanes[7:4]!=0`, go to BEAT1.
  - Otherwise go to IDLE, or reload BEAT0 if a new request is accepted in the same cycle.
- **BEAT1 outputs:** `mem_addr=base+4` (wraps modulo 2^ADDR_W), `mem_wstrb=lanes[7:4]`, `mem_wdata=shdata[63:32]`.
- **BEAT1 exit on `mem_ready`:** go to IDLE, or BEAT0 if a new request is accepted in the same cycle.
- **Strobe rule:** lanes with a strobe of 0 drive 0 on `mem_wdata`.
- **Illegal `Type_sel`:**
  - The request is still accepted and no beat is issued.
  - `req_err` pulses high the cycle after acceptance.
  - The state stays in, or returns to, IDLE.
- **Stability:** while `mem_valid && !mem_ready`, `mem_addr`, `mem_wdata` and `mem_wstrb` hold stable.
- **Reset, including mid-operation:**
  - State goes to IDLE and any pending beat is dropped.
  - `mem_valid`=0, `req_err`=0, `busy`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0.
  - `req_ready`=1.

## Timing
- Request accepted at edge N gives `mem_valid`=1 in cycle N+1. The latency is one cycle, fully registered.
- An aligned store completes in 1 beat; the minimum occupancy is 1 cycle.
- A split store takes 2 beats. The minimum is 2 cycles; BEAT1 follows BEAT0's handshake immediately.
- Sustained throughput is one aligned store per cycle when `mem_ready` is held high.
- `req_err` asserts in cycle N+1 for exactly one cycle. `mem_valid` stays 0 in that cycle unless a legal request is accepted at edge N+1.
- `mem_valid` may not depend combinationally on `mem_ready`. `req_ready` may depend combinationally on `mem_ready`.

## Structure
- **Shared package `store_pkg`:**
  - funct3 size constants: `ST_B=2'b00`, `ST_H=2'b01`, `ST_W=2'b10`.
  - state enum: `st_idle`, `st_beat0`, `st_beat1`.
  - `LANES=4`.
- **Combinational sub-module `store_lane_gen`:** (`addr[1:0]`, `Type_sel`, `data`) → (`lanes[7:0]`, `shdata[63:0]`, `illegal`). The top level holds the FSM and the output registers.

## Test plan
- Aligned word: `addr=0x100`, `data=0xDEADBEEF`, `Type_sel=010`, `mem_ready=1`. Expect one beat at 0x100, `wstrb=1111`, `wdata=0xDEADBEEF`, in cycle N+1.
- Byte at offset 3: `addr=0x203`, `data=0x123456AB`, `Type_sel=000`. Expect one beat at 0x200, `wstrb=1000`, `wdata=0xAB000000`.
- Split half: `addr=0x307`, `data=0x0000CAFE`, `Type_sel=001`. Expect beat 0x304 with `wstrb=1000`, `wdata=0xFE000000`, then beat 0x308 with `wstrb=0001`, `wdata=0x000000CA`. `req_ready`=0 during BEAT0.
- Backpressure: split word at `addr=0x401`, with `mem_ready` low for 3 cycles on each beat. Expect outputs held stable. Beats are 0x400 with `wstrb=1110` and 0x404 with `wstrb=0001`. No new request is accepted until the final handshake.
- Illegal `Type_sel=011` and then `Type_sel=100`: each is accepted, `req_err` pulses 1 cycle later, and `mem_valid` never rises.
- Reset asserted asynchronously during BEAT1 of a split store: `mem_valid` drops immediately, and after release the state is IDLE with `req_ready`=1 and no residual beat issued.
